cl_decode_pipe: RTL and testbench
=================================

CL_DECODE_PIPE -- requirements
Module: cl_decode_pipe

Interface
REQ-001 Parameter SKID_EN, default 1: 1 = two-entry buffer with registered in_ready_o; 0 = single output register.
REQ-002 Parameter HAZARD_EN, default 1: 1 = load-use bubble insertion enabled; 0 = disabled.
REQ-003 Parameter CNT_W, default 16: width of bubble_count_o.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  upstream instruction valid.
REQ-007 instruction_i  input  instruction_s  upstream instruction.
REQ-008 in_ready_o  output  1  stage can accept instruction_i this cycle.
REQ-009 flush_i  input  1  synchronous discard of all held instructions.
REQ-010 out_valid_o  output  1  decoded instruction valid downstream.
REQ-011 out_ready_i  input  1  downstream accepts this cycle.
REQ-012 instruction_o  output  instruction_s  head instruction.
REQ-013 is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o, is_byte_op_o  output  1 each  registered decode flags of instruction_o.
REQ-014 bubble_count_o  output  CNT_W  count of inserted load-use bubbles.

Function
REQ-015 Decode classes SHALL be: load = kLW,kLBU; writes_rf = kADDU,kSUBU,kSLLV,kSRAV,kSRLV,kAND,kOR,kNOR,kSLT,kSLTU,kMOV,kROL,kJALR,kLW,kLBU; mem = kLW,kLBU,kSW,kSB; store = kSW,kSB; byte = kLBU,kSB; any other encoding SHALL produce all flags 0.
REQ-016 Flags SHALL be computed at accept time and stored alongside the instruction; outputs SHALL reflect the head entry only.
REQ-017 Accept occurs when in_valid_i & in_ready_o; release occurs when out_valid_o & out_ready_i.
REQ-018 Latency: an instruction accepted into an empty stage SHALL appear on out_valid_o the following cycle.
REQ-019 SKID_EN=1: states EMPTY, ONE, TWO; in_ready_o = (state != TWO), driven from a register.
REQ-020 EMPTY: accept -> ONE.
REQ-021 ONE: accept without release -> TWO; release without accept -> EMPTY; accept with release, or neither -> ONE.
REQ-022 TWO: release -> ONE, with the skid entry becoming head; no accept is possible in TWO.
REQ-023 SKID_EN=0: a single register; in_ready_o = ~out_valid_o | (out_ready_i & ~bubble), combinational.
REQ-024 Order SHALL be preserved; no instruction SHALL be duplicated or dropped except by flush_i or reset.
REQ-025 HAZARD_EN=1: on release of a load, the stage SHALL record load_pend=1 and its rd field for exactly the next cycle.
REQ-026 Bubble: a cycle is a bubble when load_pend=1 and the head's rs or rd field equals the recorded rd.
REQ-027 During a bubble: out_valid_o SHALL be 0, the head SHALL be held, and the cycle SHALL count as no release.
REQ-028 Bubbles are one cycle only: load_pend SHALL clear the following cycle regardless of release.
REQ-029 bubble_count_o SHALL increment by 1 per bubble cycle and saturate at 2^CNT_W-1.
REQ-030 flush_i=1: state -> EMPTY, load_pend -> 0, in_ready_o forced 0 that cycle, no accept and no release; flush wins over every simultaneous event.
REQ-031 flush_i SHALL NOT alter bubble_count_o.
REQ-032 HAZARD_EN=0: no bubbles are inserted and bubble_count_o SHALL remain 0.

Reset
REQ-033 n_reset low SHALL immediately set state EMPTY, out_valid_o 0, all flags 0, instruction_o 0, load_pend 0 and bubble_count_o 0.
REQ-034 n_reset low SHALL set in_ready_o to 1 (SKID_EN=1), or to 1 via out_valid_o=0 (SKID_EN=0).
REQ-035 Reset asserted mid-operation SHALL discard all held instructions, with no partial output.
REQ-036 The first accept SHALL occur on the first rising edge after n_reset deasserts.

Verification
REQ-037 Stream kADDU, kLW, kSB with out_ready_i=1 -> outputs appear 1 cycle after each accept; flags 01000, 11010, 00111 in order (load, writes_rf, store, mem, byte); no stalls.
REQ-038 SKID_EN=1: hold out_ready_i=0 and offer 3 instructions -> 2 accepted, in_ready_o=0 from the cycle after the second accept; raise out_ready_i -> all 3 emerge in order.
REQ-039 Release kLW with rd=3, followed by kADDU with rs=3 -> exactly one cycle of out_valid_o=0; bubble_count_o goes 0->1; kADDU released next cycle.
REQ-040 kLW with rd=3 followed by an instruction with no field equal to 3 -> no bubble; bubble_count_o stays 0.
REQ-041 In state TWO, assert flush_i together with in_valid_i and out_ready_i -> next cycle out_valid_o=0, state EMPTY, nothing accepted or released.
REQ-042 CNT_W=2: force 5 bubbles -> bubble_count_o reads 1,2,3,3,3; pulse n_reset low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cl_decode_pipe_if.sv
// cl_decode_pipe_if: handshake bundle for the decode stage.
//   Upstream:   in_valid_i, instruction_i -> stage; in_ready_o <- stage.
//   Control:    flush_i -> stage.
//   Downstream: out_valid_o, instruction_o, decode flags, bubble_count_o
//               <- stage; out_ready_i -> stage.
// instr_t is a type parameter, so this file does not depend on the package
// that defines the instruction layout.
interface cl_decode_pipe_if #(
  parameter type instr_t = logic [31:0],
  parameter int  CNT_W   = 16
);
  logic             in_valid_i;
  instr_t           instruction_i;
  logic             in_ready_o;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  instr_t           instruction_o;
  logic             is_load_op_o;
  logic             op_writes_rf_o;
  logic             is_store_op_o;
  logic             is_mem_op_o;
  logic             is_byte_op_o;
  logic [CNT_W-1:0] bubble_count_o;

  // Stage side.
  modport slave (
    input  in_valid_i, instruction_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, instruction_o,
           is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o,
           is_byte_op_o, bubble_count_o
  );

  // Producer/consumer side.
  modport master (
    output in_valid_i, instruction_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, instruction_o,
           is_load_op_o, op_writes_rf_o, is_store_op_o, is_mem_op_o,
           is_byte_op_o, bubble_count_o
  );
endinterface

// File: rtl/cl_decode_pipe.sv
// cl_decode_pkg: instruction layout and decode flag record.
// cl_decode_pipe: decode stage with optional two-entry skid buffer and
// load-use bubble insertion.
//   clk      rising-edge clock
//   n_reset  asynchronous active-low reset
//   bus      cl_decode_pipe_if.slave (instr_t = cl_decode_pkg::instruction_s,
//            CNT_W must match the module parameter)
package cl_decode_pkg;
  typedef enum logic [5:0] {
    kNOP = 6'd0, kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT,
    kSLTU, kMOV, kROL, kJALR, kLW, kLBU, kSW, kSB, kBEQ, kJ
  } opcode_e;

  typedef struct packed {
    opcode_e     op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [15:0] imm;
  } instruction_s;

  typedef struct packed {
    logic load;
    logic wrf;
    logic store;
    logic mem;
    logic bop;
  } flags_s;
endpackage

module cl_decode_pipe #(
  parameter int SKID_EN   = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           n_reset,
  cl_decode_pipe_if.slave bus
);
  import cl_decode_pkg::*;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    instruction_s ins;
    flags_s       fl;
  } entry_s;

  function automatic flags_s decode(input instruction_s i);
    flags_s f;
    f = '0;
    case (i.op)
      kLW:  f = flags_s'(5'b11010);
      kLBU: f = flags_s'(5'b11011);
      kSW:  f = flags_s'(5'b00110);
      kSB:  f = flags_s'(5'b00111);
      kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT, kSLTU,
      kMOV, kROL, kJALR:
            f = flags_s'(5'b01000);
      default: f = '0;
    endcase
    return f;
  endfunction

  state_e           state_q, state_d;
  entry_s           head_q, head_d, skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             pend_q, pend_d;
  logic [4:0]       prd_q, prd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   bubble, in_ready, out_valid, acc, rel;
  entry_s new_ent;

  assign new_ent = '{ins: bus.instruction_i, fl: decode(bus.instruction_i)};

  // Load-use: the head depends on the load released last cycle.
  assign bubble = (HAZARD_EN != 0) && pend_q && (state_q != EMPTY) &&
                  ((head_q.ins.rs == prd_q) || (head_q.ins.rd == prd_q));

  assign out_valid = (state_q != EMPTY) && !bubble;

  // Single-register mode looks at the held-entry valid rather than the
  // bubble-gated out_valid, otherwise a bubble would let the held head be
  // overwritten.
  assign in_ready = !bus.flush_i &&
                    ((SKID_EN != 0) ? rdy_q
                                    : ((state_q == EMPTY) ||
                                       (bus.out_ready_i && !bubble)));

  assign acc = bus.in_valid_i && in_ready;
  assign rel = out_valid && bus.out_ready_i && !bus.flush_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    pend_d  = 1'b0;
    prd_d   = prd_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin
          head_d  = new_ent;
          state_d = ONE;
        end
        ONE: begin
          if (acc && rel) begin
            head_d = new_ent;
          end else if (acc) begin
            skid_d  = new_ent;
            state_d = TWO;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        TWO: if (rel) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
      if (rel && (HAZARD_EN != 0) && head_q.fl.load) begin
        pend_d = 1'b1;
        prd_d  = head_q.ins.rd;
      end
      if (bubble && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      pend_q  <= 1'b0;
      prd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      pend_q  <= pend_d;
      prd_q   <= prd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.out_valid_o    = out_valid;
  assign bus.instruction_o  = head_q.ins;
  assign bus.is_load_op_o   = head_q.fl.load;
  assign bus.op_writes_rf_o = head_q.fl.wrf;
  assign bus.is_store_op_o  = head_q.fl.store;
  assign bus.is_mem_op_o    = head_q.fl.mem;
  assign bus.is_byte_op_o   = head_q.fl.bop;
  assign bus.bubble_count_o = cnt_q;
endmodule

// File: tb/tb_cl_decode_pipe.sv
// Bench for cl_decode_pipe: three instances share one stimulus stream
//   u_a: SKID_EN=1 HAZARD_EN=1 CNT_W=16
//   u_b: SKID_EN=0 HAZARD_EN=1 CNT_W=2
//   u_c: SKID_EN=1 HAZARD_EN=0 CNT_W=16
// Directed table + hand sequences, then random traffic against a queue model.
module tb_cl_decode_pipe;
  import cl_decode_pkg::*;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic         tin_valid = 1'b0;
  instruction_s tins = '0;
  logic         tout_ready = 1'b0;
  logic         tflush = 1'b0;

  cl_decode_pipe_if #(.instr_t(instruction_s), .CNT_W(16)) ia ();
  cl_decode_pipe_if #(.instr_t(instruction_s), .CNT_W(2))  ib ();
  cl_decode_pipe_if #(.instr_t(instruction_s), .CNT_W(16)) ic ();

  assign ia.in_valid_i = tin_valid;  assign ia.instruction_i = tins;
  assign ia.out_ready_i = tout_ready; assign ia.flush_i = tflush;
  assign ib.in_valid_i = tin_valid;  assign ib.instruction_i = tins;
  assign ib.out_ready_i = tout_ready; assign ib.flush_i = tflush;
  assign ic.in_valid_i = tin_valid;  assign ic.instruction_i = tins;
  assign ic.out_ready_i = tout_ready; assign ic.flush_i = tflush;

  cl_decode_pipe #(.SKID_EN(1), .HAZARD_EN(1), .CNT_W(16)) u_a (.clk(clk), .n_reset(n_reset), .bus(ia));
  cl_decode_pipe #(.SKID_EN(0), .HAZARD_EN(1), .CNT_W(2))  u_b (.clk(clk), .n_reset(n_reset), .bus(ib));
  cl_decode_pipe #(.SKID_EN(1), .HAZARD_EN(0), .CNT_W(16)) u_c (.clk(clk), .n_reset(n_reset), .bus(ic));

  logic         obs_v   [3];
  logic         obs_r   [3];
  instruction_s obs_ins [3];
  logic [4:0]   obs_fl  [3];
  logic [31:0]  obs_cnt [3];

  assign obs_v[0] = ia.out_valid_o; assign obs_r[0] = ia.in_ready_o; assign obs_ins[0] = ia.instruction_o;
  assign obs_v[1] = ib.out_valid_o; assign obs_r[1] = ib.in_ready_o; assign obs_ins[1] = ib.instruction_o;
  assign obs_v[2] = ic.out_valid_o; assign obs_r[2] = ic.in_ready_o; assign obs_ins[2] = ic.instruction_o;
  assign obs_fl[0] = {ia.is_load_op_o, ia.op_writes_rf_o, ia.is_store_op_o, ia.is_mem_op_o, ia.is_byte_op_o};
  assign obs_fl[1] = {ib.is_load_op_o, ib.op_writes_rf_o, ib.is_store_op_o, ib.is_mem_op_o, ib.is_byte_op_o};
  assign obs_fl[2] = {ic.is_load_op_o, ic.op_writes_rf_o, ic.is_store_op_o, ic.is_mem_op_o, ic.is_byte_op_o};
  assign obs_cnt[0] = {16'd0, ia.bubble_count_o};
  assign obs_cnt[1] = {30'd0, ib.bubble_count_o};
  assign obs_cnt[2] = {16'd0, ic.bubble_count_o};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic instruction_s mk(input opcode_e op, input int rd, input int rs);
    instruction_s i;
    i.op  = op;
    i.rd  = 5'(rd);
    i.rs  = 5'(rs);
    i.imm = 16'(rd * 257 + rs);
    return i;
  endfunction

  // Reference decode straight from the class lists: {load, wrf, store, mem, byte}.
  function automatic logic [4:0] ref_flags(input instruction_s i);
    logic ld, wr, st, mem, by;
    ld  = i.op inside {kLW, kLBU};
    st  = i.op inside {kSW, kSB};
    mem = i.op inside {kLW, kLBU, kSW, kSB};
    by  = i.op inside {kLBU, kSB};
    wr  = i.op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR,
                       kSLT, kSLTU, kMOV, kROL, kJALR, kLW, kLBU};
    return {ld, wr, st, mem, by};
  endfunction

  // ---------------- reference model (random phase) ----------------
  bit           model_en = 1'b0;
  instruction_s mq [3][$];
  bit           mpend [3];
  logic [4:0]   mprd  [3];
  int           mcnt  [3];
  int           mskid [3] = '{1, 0, 1};
  int           mhaz  [3] = '{1, 1, 0};
  int           mmax  [3] = '{65535, 3, 65535};
  int           cyc = 0;

  always @(negedge clk) begin
    if (model_en) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
        int hsz;
        bit bub, ev, er, acc, rel;
        instruction_s hd;
        hsz = mq[k].size();
        hd  = (hsz > 0) ? mq[k][0] : '0;
        bub = (mhaz[k] != 0) && mpend[k] && (hsz > 0) &&
              ((hd.rs == mprd[k]) || (hd.rd == mprd[k]));
        ev  = (hsz > 0) && !bub;
        if (tflush) er = 1'b0;
        else if (mskid[k] != 0) er = (hsz < 2);
        else er = (hsz == 0) || (tout_ready && !bub);
        chk($sformatf("rand c%0d u%0d out_valid", cyc, k), 32'(obs_v[k]), 32'(ev));
        chk($sformatf("rand c%0d u%0d in_ready", cyc, k), 32'(obs_r[k]), 32'(er));
        chk($sformatf("rand c%0d u%0d count", cyc, k), obs_cnt[k], 32'(mcnt[k]));
        if (ev) begin
          chk($sformatf("rand c%0d u%0d instr", cyc, k), 32'(obs_ins[k]), 32'(hd));
          chk($sformatf("rand c%0d u%0d flags", cyc, k), 32'(obs_fl[k]), 32'(ref_flags(hd)));
        end
        acc = tin_valid && er;
        rel = ev && tout_ready && !tflush;
        if (tflush) begin
          mq[k].delete();
          mpend[k] = 1'b0;
        end else begin
          mpend[k] = 1'b0;
          if (rel) begin
            mpend[k] = (mhaz[k] != 0) && ref_flags(hd)[4];
            mprd[k]  = hd.rd;
            void'(mq[k].pop_front());
          end
          if (acc) mq[k].push_back(tins);
          if (bub && mcnt[k] < mmax[k]) mcnt[k]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    instruction_s ins;
    logic [4:0]   fl;
  } vec_t;
  vec_t tbl [12];

  task automatic reset_all();
    n_reset = 1'b0;
    tin_valid = 1'b0; tflush = 1'b0; tout_ready = 1'b0; tins = '0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    instruction_s a, b, c;
    tbl[0]  = '{mk(kADDU, 1, 2),   5'b01000};
    tbl[1]  = '{mk(kLW, 3, 4),     5'b11010};
    tbl[2]  = '{mk(kSB, 5, 6),     5'b00111};
    tbl[3]  = '{mk(kLBU, 7, 8),    5'b11011};
    tbl[4]  = '{mk(kSW, 9, 10),    5'b00110};
    tbl[5]  = '{mk(kJALR, 11, 12), 5'b01000};
    tbl[6]  = '{mk(kNOP, 13, 14),  5'b00000};
    tbl[7]  = '{mk(kBEQ, 15, 16),  5'b00000};
    tbl[8]  = '{mk(kROL, 17, 18),  5'b01000};
    tbl[9]  = '{mk(kSUBU, 19, 20), 5'b01000};
    tbl[10] = '{mk(kSLT, 21, 22),  5'b01000};
    tbl[11] = '{mk(kJ, 23, 24),    5'b00000};

    // Reset state, checked while reset is held.
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset u%0d out_valid", k), 32'(obs_v[k]), 32'd0);
      chk($sformatf("reset u%0d in_ready", k), 32'(obs_r[k]), 32'd1);
      chk($sformatf("reset u%0d instr", k), 32'(obs_ins[k]), 32'd0);
      chk($sformatf("reset u%0d flags", k), 32'(obs_fl[k]), 32'd0);
      chk($sformatf("reset u%0d count", k), obs_cnt[k], 32'd0);
    end

    // Back-to-back stream: each entry shows up the cycle after it is offered.
    reset_all();
    tin_valid = 1'b1; tins = tbl[0].ins; tout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i + 1 < 12) tins = tbl[i + 1].ins;
      else tin_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d out_valid", i), 32'(obs_v[0]), 32'd1);
      chk($sformatf("tbl%0d in_ready", i), 32'(obs_r[0]), 32'd1);
      chk($sformatf("tbl%0d instr", i), 32'(obs_ins[0]), 32'(tbl[i].ins));
      chk($sformatf("tbl%0d flags", i), 32'(obs_fl[0]), 32'(tbl[i].fl));
    end

    // Skid fill with a stalled consumer, then drain in order.
    reset_all();
    a = mk(kADDU, 1, 1); b = mk(kOR, 2, 2); c = mk(kSW, 4, 4);
    tout_ready = 1'b0; tin_valid = 1'b1; tins = a;
    @(posedge clk); #1 tins = b;
    @(negedge clk);
    chk("skid one in_ready", 32'(obs_r[0]), 32'd1);
    chk("skid one head", 32'(obs_ins[0]), 32'(a));
    @(posedge clk); #1 tins = c;
    @(negedge clk);
    chk("skid two in_ready", 32'(obs_r[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("skid hold in_ready", 32'(obs_r[0]), 32'd0);
    chk("skid hold head", 32'(obs_ins[0]), 32'(a));
    tout_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain b valid", 32'(obs_v[0]), 32'd1);
    chk("drain b instr", 32'(obs_ins[0]), 32'(b));
    chk("drain b in_ready", 32'(obs_r[0]), 32'd1);
    @(posedge clk); #1 tin_valid = 1'b0;
    @(negedge clk);
    chk("drain c valid", 32'(obs_v[0]), 32'd1);
    chk("drain c instr", 32'(obs_ins[0]), 32'(c));
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain empty", 32'(obs_v[0]), 32'd0);

    // Load followed by an unrelated op: no bubble.
    reset_all();
    tout_ready = 1'b1; tin_valid = 1'b1; tins = mk(kLW, 3, 1);
    @(posedge clk); #1 tins = mk(kADDU, 4, 5);
    @(posedge clk); #1 tin_valid = 1'b0;
    @(negedge clk);
    chk("nohaz valid", 32'(obs_v[0]), 32'd1);
    chk("nohaz count", obs_cnt[0], 32'd0);
    idle_cycle();

    // Load followed by a dependent op: exactly one bubble.
    tin_valid = 1'b1; tins = mk(kLW, 3, 1);
    @(posedge clk); #1 tins = mk(kADDU, 6, 3);
    @(posedge clk); #1 tin_valid = 1'b0;
    @(negedge clk);
    chk("haz bubble valid", 32'(obs_v[0]), 32'd0);
    chk("haz bubble count", obs_cnt[0], 32'd0);
    chk("nohazard-inst valid", 32'(obs_v[2]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("haz after valid", 32'(obs_v[0]), 32'd1);
    chk("haz after instr", 32'(obs_ins[0]), 32'(mk(kADDU, 6, 3)));
    chk("haz after count", obs_cnt[0], 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("haz drained", 32'(obs_v[0]), 32'd0);

    // Flush while full, with simultaneous valid and ready.
    reset_all();
    tout_ready = 1'b0; tin_valid = 1'b1; tins = a;
    @(posedge clk); #1 tins = b;
    @(posedge clk); #1 tins = c; tflush = 1'b1; tout_ready = 1'b1;
    @(negedge clk);
    chk("flush in_ready", 32'(obs_r[0]), 32'd0);
    @(posedge clk); #1 tflush = 1'b0; tin_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 32'(obs_v[0]), 32'd0);
    chk("flush in_ready after", 32'(obs_r[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush nothing kept", 32'(obs_v[0]), 32'd0);

    // Five bubbles into a 2-bit counter.
    reset_all();
    tout_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tin_valid = 1'b1; tins = mk(kLW, 3, 1);
      @(posedge clk); #1 tins = mk(kADDU, 7, 3);
      @(posedge clk); #1 tin_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("sat count %0d", k), obs_cnt[1], 32'((k < 3) ? k : 3));
    end
    chk("nohazard-inst count", obs_cnt[2], 32'd0);

    // Asynchronous reset mid-stream.
    tin_valid = 1'b1; tins = mk(kLW, 3, 1);
    @(posedge clk); #2 n_reset = 1'b0;
    #1;
    chk("areset u_b out_valid", 32'(obs_v[1]), 32'd0);
    chk("areset u_b instr", 32'(obs_ins[1]), 32'd0);
    chk("areset u_b flags", 32'(obs_fl[1]), 32'd0);
    chk("areset u_b count", obs_cnt[1], 32'd0);
    chk("areset u_b in_ready", 32'(obs_r[1]), 32'd1);
    chk("areset u_a out_valid", 32'(obs_v[0]), 32'd0);
    chk("areset u_a count", obs_cnt[0], 32'd0);
    tin_valid = 1'b0;
    @(negedge clk) n_reset = 1'b1;

    // Random traffic against the model.
    reset_all();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete(); mpend[k] = 1'b0; mprd[k] = '0; mcnt[k] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      tin_valid  = ($urandom_range(0, 9) < 7);
      tout_ready = ($urandom_range(0, 9) < 7);
      tflush     = ($urandom_range(0, 39) == 0);
      tins.op    = opcode_e'(6'($urandom_range(0, 23)));
      tins.rd    = 5'($urandom_range(0, 3));
      tins.rs    = 5'($urandom_range(0, 3));
      tins.imm   = 16'($urandom);
      if (n == 0) model_en = 1'b1;
    end
    @(negedge clk);
    #1 model_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
